mc_control_fsm: RTL

Multi-cycle main control unit for the MIPS datapath. A Moore state machine sequences instruction fetch, decode, execute, memory and write-back. Each cycle it drives every datapath select and write-enable:
- the 4:1 ALU source-B select (`ALUSrcB`),
- the ALU source-A select, PC/IR/memory/register-file enables and PC source.

It sits beside the datapath, takes the opcode/funct fields from the instruction register, and is the single owner of every mux select in the core.

---
 rtl/mc_control_fsm.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control: Moore FSM driving every datapath select/enable.
// Optional macro CTRL_EXCEPTION_EN routes undefined opcodes and overflow to EXCEPT.
module mc_control_fsm #(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Overflow,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       EPCWrite,
    output logic       ResetOut,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_FWAIT     = 4'd2,
        S_DECODE    = 4'd3,
        S_MEMADDR   = 4'd4,
        S_MEMREAD   = 4'd5,
        S_MRWAIT    = 4'd6,
        S_MEMWB     = 4'd7,
        S_MEMWRITE  = 4'd8,
        S_EXECUTE   = 4'd9,
        S_RTYPE_WB  = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_ADDI_EXEC = 4'd13,
        S_ADDI_WB   = 4'd14,
        S_EXCEPT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Counter starts at MEM_WAIT-1 so that the wait state runs MEM_WAIT cycles.
    localparam int         WAIT_INIT = (MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0;
    localparam logic [1:0] WAIT_LOAD = WAIT_INIT[1:0];

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_wait;
    logic       r_is_lw;
    logic       r_is_jr;
    logic       w_dec_jr;

    assign w_dec_jr = (Opcode == OP_RTYPE) && (Funct == FN_JR);
    assign State    = r_state;

`ifndef CTRL_EXCEPTION_EN
    logic w_unused_ovf;
    assign w_unused_ovf = Overflow;
`endif

    // Instruction class is latched in DECODE so later-state outputs depend on registers only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RESET;
            r_wait  <= 2'd0;
            r_is_lw <= 1'b0;
            r_is_jr <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_is_lw <= (Opcode == OP_LW);
                r_is_jr <= w_dec_jr;
            end
            if ((r_state == S_FWAIT) || (r_state == S_MRWAIT)) begin
                if (r_wait != 2'd0) begin
                    r_wait <= r_wait - 2'd1;
                end
            end else begin
                r_wait <= WAIT_LOAD;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        EPCWrite    = 1'b0;
        ResetOut    = 1'b0;

        case (r_state)
            S_RESET: begin
                ResetOut = 1'b1;
                w_next   = S_FETCH;
            end
            S_FETCH: begin
                ALUSrcB = 2'b01;
                if (MEM_WAIT == 0) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_DECODE;
                end else begin
                    w_next  = S_FWAIT;
                end
            end
            S_FWAIT: begin
                ALUSrcB = 2'b01;
                if (r_wait == 2'd0) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_RTYPE:      w_next = S_EXECUTE;
                    OP_LW, OP_SW:  w_next = S_MEMADDR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_J:          w_next = S_JUMP;
                    OP_ADDI:       w_next = S_ADDI_EXEC;
`ifdef CTRL_EXCEPTION_EN
                    default:       w_next = S_EXCEPT;
`else
                    default:       w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = r_is_lw ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                IorD   = 1'b1;
                w_next = (MEM_WAIT > 0) ? S_MRWAIT : S_MEMWB;
            end
            S_MRWAIT: begin
                IorD = 1'b1;
                if (r_wait == 2'd0) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                if (r_is_jr) begin
                    PCWrite = 1'b1;
                    w_next  = S_FETCH;
                end else begin
`ifdef CTRL_EXCEPTION_EN
                    w_next = Overflow ? S_EXCEPT : S_RTYPE_WB;
`else
                    w_next = S_RTYPE_WB;
`endif
                end
            end
            S_RTYPE_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCSource    = 2'b01;
                PCWriteCond = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                w_next   = S_FETCH;
            end
            S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
`ifdef CTRL_EXCEPTION_EN
                w_next  = Overflow ? S_EXCEPT : S_ADDI_WB;
`else
                w_next  = S_ADDI_WB;
`endif
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_EXCEPT: begin
`ifdef CTRL_EXCEPTION_EN
                EPCWrite = 1'b1;
                PCSource = 2'b11;
                PCWrite  = 1'b1;
`endif
                w_next   = S_FETCH;
            end
            default: begin
                w_next = S_RESET;
            end
        endcase
    end

endmodule
